// File: rtl/gecko_mem_arbiter.sv
// rtl/gecko_mem_arbiter.sv - two-requester round-robin memory arbiter with in-order read response routing
module gecko_mem_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 req0_valid,
   output logic                                 req0_ready,
   input  logic                                 req0_read_enable,
   input  logic [DATA_WIDTH/8-1:0]              req0_write_enable,
   input  logic [ADDR_WIDTH-1:0]                req0_addr,
   input  logic [DATA_WIDTH-1:0]                req0_data,
   input  logic                                 req1_valid,
   output logic                                 req1_ready,
   input  logic                                 req1_read_enable,
   input  logic [DATA_WIDTH/8-1:0]              req1_write_enable,
   input  logic [ADDR_WIDTH-1:0]                req1_addr,
   input  logic [DATA_WIDTH-1:0]                req1_data,
   output logic                                 rsp0_valid,
   input  logic                                 rsp0_ready,
   output logic [DATA_WIDTH-1:0]                rsp0_data,
   output logic                                 rsp1_valid,
   input  logic                                 rsp1_ready,
   output logic [DATA_WIDTH-1:0]                rsp1_data,
   output logic                                 mem_req_valid,
   input  logic                                 mem_req_ready,
   output logic                                 mem_req_read_enable,
   output logic [DATA_WIDTH/8-1:0]              mem_req_write_enable,
   output logic [ADDR_WIDTH-1:0]                mem_req_addr,
   output logic [DATA_WIDTH-1:0]                mem_req_data,
   input  logic                                 mem_rsp_valid,
   output logic                                 mem_rsp_ready,
   input  logic [DATA_WIDTH-1:0]                mem_rsp_data,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding,
   output logic                                 rsp_error
);
   localparam int PTR_WIDTH = $clog2(MAX_OUTSTANDING);
   localparam int CNT_WIDTH = PTR_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(MAX_OUTSTANDING);

   logic                       last_grant;
   logic                       lock_valid;
   logic                       lock_id;
   logic [PTR_WIDTH-1:0]       wr_ptr;
   logic [PTR_WIDTH-1:0]       rd_ptr;
   logic [MAX_OUTSTANDING-1:0] order_fifo;
   logic                       full, elig0, elig1;
   logic                       grant_valid, grant_id;
   logic                       accept, push, pop, has_out, head_id;

   assign full  = (outstanding == CNT_FULL);
   assign elig0 = req0_valid & (~req0_read_enable | ~full);
   assign elig1 = req1_valid & (~req1_read_enable | ~full);

   // A stalled winner keeps the grant until memory accepts it.
   always_comb begin
      grant_valid = 1'b0;
      grant_id    = 1'b0;
      if (rst) begin
         if (lock_valid && (lock_id ? elig1 : elig0)) begin
            grant_valid = 1'b1;
            grant_id    = lock_id;
         end else if (elig0 && elig1) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant;
         end else if (elig0) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
         end else if (elig1) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
         end
      end
   end

   always_comb begin
      mem_req_read_enable  = 1'b0;
      mem_req_write_enable = '0;
      mem_req_addr         = '0;
      mem_req_data         = '0;
      if (grant_valid) begin
         if (grant_id) begin
            mem_req_read_enable  = req1_read_enable;
            mem_req_write_enable = req1_write_enable;
            mem_req_addr         = req1_addr;
            mem_req_data         = req1_data;
         end else begin
            mem_req_read_enable  = req0_read_enable;
            mem_req_write_enable = req0_write_enable;
            mem_req_addr         = req0_addr;
            mem_req_data         = req0_data;
         end
      end
   end

   assign mem_req_valid = grant_valid;
   assign req0_ready    = grant_valid & ~grant_id & mem_req_ready;
   assign req1_ready    = grant_valid &  grant_id & mem_req_ready;
   assign accept        = grant_valid & mem_req_ready;
   assign push          = accept & mem_req_read_enable;

   // Responses are steered to whoever issued the oldest outstanding read.
   assign has_out       = (outstanding != '0);
   assign head_id       = order_fifo[rd_ptr];
   assign rsp0_valid    = rst & has_out & ~head_id & mem_rsp_valid;
   assign rsp1_valid    = rst & has_out &  head_id & mem_rsp_valid;
   assign rsp0_data     = (has_out & ~head_id) ? mem_rsp_data : '0;
   assign rsp1_data     = (has_out &  head_id) ? mem_rsp_data : '0;
   assign mem_rsp_ready = rst & has_out & (head_id ? rsp1_ready : rsp0_ready);
   assign pop           = mem_rsp_valid & mem_rsp_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant  <= 1'b1;
         lock_valid  <= 1'b0;
         lock_id     <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         order_fifo  <= '0;
         outstanding <= '0;
         rsp_error   <= 1'b0;
      end else begin
         if (accept) last_grant <= grant_id;
         lock_valid <= grant_valid & ~mem_req_ready;
         lock_id    <= grant_id;
         if (push) begin
            order_fifo[wr_ptr] <= grant_id;
            wr_ptr             <= wr_ptr + PTR_WIDTH'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
         case ({push, pop})
            2'b10:   outstanding <= outstanding + CNT_WIDTH'(1);
            2'b01:   outstanding <= outstanding - CNT_WIDTH'(1);
            default: outstanding <= outstanding;
         endcase
         if (mem_rsp_valid && !has_out) rsp_error <= 1'b1;
      end
   end
endmodule

// File: tb/tb_gecko_mem_arbiter.sv
// tb/tb_gecko_mem_arbiter.sv - randomized and directed bench for gecko_mem_arbiter against a queue-based model
module tb_gecko_mem_arbiter;
   localparam int AW = 32, DW = 32, MW = 4, MAXO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_ready, req0_read_enable;
   logic [MW-1:0] req0_write_enable;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_data;
   logic          req1_valid, req1_ready, req1_read_enable;
   logic [MW-1:0] req1_write_enable;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_data;
   logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [DW-1:0] rsp0_data, rsp1_data;
   logic          mem_req_valid, mem_req_ready, mem_req_read_enable;
   logic [MW-1:0] mem_req_write_enable;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_req_data;
   logic          mem_rsp_valid, mem_rsp_ready;
   logic [DW-1:0] mem_rsp_data;
   logic [2:0]    outstanding;
   logic          rsp_error;

   gecko_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_read_enable(req0_read_enable),
      .req0_write_enable(req0_write_enable), .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_read_enable(req1_read_enable),
      .req1_write_enable(req1_write_enable), .req1_addr(req1_addr), .req1_data(req1_data),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_read_enable(mem_req_read_enable), .mem_req_write_enable(mem_req_write_enable),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
      .outstanding(outstanding), .rsp_error(rsp_error)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int q[$];
   bit m_last, m_err, pop_e, err_e, exp_r0, exp_r1, h0, h1;
   int m_held, w;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic setreq(input int n, input bit v, input bit rd, input logic [MW-1:0] m,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (n == 0) begin
         req0_valid = v; req0_read_enable = rd; req0_write_enable = m; req0_addr = a; req0_data = d;
      end else begin
         req1_valid = v; req1_read_enable = rd; req1_write_enable = m; req1_addr = a; req1_data = d;
      end
   endtask

   task automatic idle();
      setreq(0, 0, 0, '0, '0, '0);
      setreq(1, 0, 0, '0, '0, '0);
      mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = '0;
      rsp0_ready = 1; rsp1_ready = 1;
   endtask

   // Model: oldest-first queue of requester ids, last winner, held (stalled) winner.
   task automatic settle();
      bit full, e0, e1, mrr;
      int h;
      #4;
      w = -1; pop_e = 0; err_e = 0;
      if (rst) begin
         full = (q.size() == MAXO);
         e0 = req0_valid && (!req0_read_enable || !full);
         e1 = req1_valid && (!req1_read_enable || !full);
         if (m_held >= 0 && ((m_held == 0) ? e0 : e1)) w = m_held;
         else if (e0 && e1) w = m_last ? 0 : 1;
         else if (e0) w = 0;
         else if (e1) w = 1;
      end
      exp_r0 = (w == 0) && mem_req_ready;
      exp_r1 = (w == 1) && mem_req_ready;
      chk("mem_req_valid", mem_req_valid, w >= 0);
      chk("mem_req_addr", mem_req_addr, w == 0 ? req0_addr : (w == 1 ? req1_addr : '0));
      chk("mem_req_data", mem_req_data, w == 0 ? req0_data : (w == 1 ? req1_data : '0));
      chk("mem_req_wen", mem_req_write_enable,
          w == 0 ? req0_write_enable : (w == 1 ? req1_write_enable : '0));
      chk("mem_req_ren", mem_req_read_enable,
          w == 0 ? req0_read_enable : (w == 1 ? req1_read_enable : 1'b0));
      chk("req0_ready", req0_ready, exp_r0);
      chk("req1_ready", req1_ready, exp_r1);
      if (rst && q.size() > 0) begin
         h = q[0];
         mrr = (h == 0) ? rsp0_ready : rsp1_ready;
         chk("rsp0_valid", rsp0_valid, (h == 0) && mem_rsp_valid);
         chk("rsp1_valid", rsp1_valid, (h == 1) && mem_rsp_valid);
         chk("mem_rsp_ready", mem_rsp_ready, mrr);
         if (mem_rsp_valid) chk("rsp_head_data", (h == 0) ? rsp0_data : rsp1_data, mem_rsp_data);
         pop_e = mem_rsp_valid && mrr;
      end else begin
         chk("rsp0_valid_idle", rsp0_valid, 0);
         chk("rsp1_valid_idle", rsp1_valid, 0);
         chk("mem_rsp_ready_idle", mem_rsp_ready, 0);
         err_e = rst && mem_rsp_valid;
      end
      chk("outstanding", outstanding, rst ? q.size() : 0);
      chk("rsp_error", rsp_error, rst ? m_err : 1'b0);
   endtask

   task automatic tick();
      int tmp;
      if (!rst) begin
         q.delete(); m_last = 1; m_held = -1; m_err = 0;
      end else begin
         if (pop_e) tmp = q.pop_front();
         if (w >= 0 && mem_req_ready) begin
            m_last = (w == 1);
            if ((w == 0) ? req0_read_enable : req1_read_enable) q.push_back(w);
         end
         m_held = (w >= 0 && !mem_req_ready) ? w : -1;
         if (err_e) m_err = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 20 && q.size() > 0; i++) begin
         mem_rsp_valid = 1; mem_rsp_data = $urandom;
         settle(); tick();
      end
      mem_rsp_valid = 0;
      settle();
      chk("drain_empty", outstanding, 0);
      tick();
   endtask

   initial begin
      rst = 0; idle();
      q.delete(); m_last = 1; m_held = -1; m_err = 0; h0 = 0; h1 = 0;
      @(posedge clk); #1;

      setreq(0, 1, 1, '0, 32'h100, '0); setreq(1, 1, 1, '0, 32'h200, '0); mem_rsp_valid = 1;
      settle();
      chk("rst_mem_req_valid", mem_req_valid, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_mem_rsp_ready", mem_rsp_ready, 0);
      chk("rst_outstanding", outstanding, 0);
      tick();
      mem_rsp_valid = 0; rst = 1;

      for (int i = 0; i < 6; i++) begin
         settle();
         if (i < 4) chk("rr_grant_is_req1", req1_ready, i % 2);
         else chk("rr_stall_when_full", mem_req_valid, 0);
         chk("rr_outstanding", outstanding, i < 4 ? i : 4);
         tick();
      end

      setreq(0, 1, 0, 4'hF, 32'h300, 32'hCAFE0000);
      settle();
      chk("full_write_ready0", req0_ready, 1);
      chk("full_read_blocked1", req1_ready, 0);
      chk("full_write_mask", mem_req_write_enable, 4'hF);
      tick();
      idle();
      settle();
      chk("full_outstanding_held", outstanding, 4);
      tick();

      mem_rsp_valid = 1;
      for (int i = 0; i < 4; i++) begin
         mem_rsp_data = 32'hA0 + i;
         settle();
         chk("order_head_is_req0", rsp0_valid, (i % 2) == 0);
         chk("order_outstanding", outstanding, 4 - i);
         tick();
      end
      idle();

      setreq(0, 1, 1, '0, 32'hA, '0); settle(); tick();
      idle(); setreq(1, 1, 1, '0, 32'hB, '0); settle(); tick();
      idle(); mem_rsp_valid = 1; mem_rsp_data = 32'h11;
      settle();
      chk("seq_out2", outstanding, 2);
      chk("seq_rsp0_valid", rsp0_valid, 1);
      chk("seq_rsp0_data", rsp0_data, 32'h11);
      tick();
      mem_rsp_data = 32'h22;
      settle();
      chk("seq_out1", outstanding, 1);
      chk("seq_rsp1_valid", rsp1_valid, 1);
      chk("seq_rsp1_data", rsp1_data, 32'h22);
      tick();
      mem_rsp_valid = 0;
      settle(); chk("seq_out0", outstanding, 0); tick();

      setreq(0, 1, 1, '0, 32'hC, '0); settle(); tick();
      setreq(0, 1, 1, '0, 32'hD0, '0); setreq(1, 1, 1, '0, 32'hD1, '0); mem_req_ready = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("stall_addr_req1", mem_req_addr, 32'hD1);
         chk("stall_ready1", req1_ready, 0);
         tick();
      end
      mem_req_ready = 1;
      settle(); chk("stall_accept_req1", req1_ready, 1); tick();
      drain();

      for (int c = 0; c < 800; c++) begin
         if (!h0) setreq(0, ($urandom % 4) != 0, $urandom % 2, MW'($urandom), $urandom, $urandom);
         if (!h1) setreq(1, ($urandom % 4) != 0, $urandom % 2, MW'($urandom), $urandom, $urandom);
         mem_req_ready = ($urandom % 4) != 0;
         mem_rsp_valid = (q.size() > 0) && ($urandom % 2 == 1);
         mem_rsp_data  = $urandom;
         rsp0_ready    = ($urandom % 4) != 0;
         rsp1_ready    = ($urandom % 4) != 0;
         settle();
         h0 = req0_valid && !exp_r0;
         h1 = req1_valid && !exp_r1;
         tick();
      end
      drain();

      mem_rsp_valid = 1;
      settle();
      chk("err_rsp_ready", mem_rsp_ready, 0);
      chk("err_not_yet", rsp_error, 0);
      tick();
      mem_rsp_valid = 0;
      for (int i = 0; i < 2; i++) begin
         settle(); chk("err_sticky", rsp_error, 1); tick();
      end

      for (int i = 0; i < 3; i++) begin
         setreq(0, 1, 1, '0, 32'h400 + i, '0); settle(); tick();
      end
      idle();
      settle(); chk("pre_rst_out3", outstanding, 3); tick();
      rst = 0;
      setreq(0, 1, 1, '0, 32'h500, '0); setreq(1, 1, 1, '0, 32'h600, '0); mem_rsp_valid = 1;
      settle();
      chk("mid_rst_outstanding", outstanding, 0);
      chk("mid_rst_mem_req_valid", mem_req_valid, 0);
      chk("mid_rst_rsp0_valid", rsp0_valid, 0);
      chk("mid_rst_rsp_error", rsp_error, 0);
      tick();
      rst = 1; mem_rsp_valid = 0;
      settle();
      chk("post_rst_tie_req0", req0_ready, 1);
      tick();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
